// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcode constants, decode-stage state type and opcode class helpers
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {EMPTY, FULL, STALL} id_state_t;

  function automatic logic op_uses_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

  function automatic logic op_writes_rd(input logic [6:0] op);
    return op inside {OP_R, OP_LOAD, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
  endfunction

  function automatic logic op_illegal(input logic [6:0] op);
    return !(op inside {OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH,
                        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR});
  endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// rtl/id_issue_ctrl_if.sv - fetch, execute and writeback signals seen by the decode-stage controller
interface id_issue_ctrl_if #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
);
  logic                   if_valid;
  logic                   if_ready;
  logic [XLEN-1:0]        if_instr;
  logic [XLEN-1:0]        if_pc;
  logic                   flush;
  logic                   id_valid;
  logic                   id_ready;
  logic [XLEN-1:0]        id_instr;
  logic [XLEN-1:0]        id_pc;
  logic                   id_illegal;
  logic                   wb_valid;
  logic [4:0]             wb_rd;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output if_valid, if_instr, if_pc, flush, id_ready, wb_valid, wb_rd,
    input  if_ready, id_valid, id_instr, id_pc, id_illegal, stall_cnt
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, id_ready, wb_valid, wb_rd,
    output if_ready, id_valid, id_instr, id_pc, id_illegal, stall_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write bit per architectural register, x0 hard-wired clear
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic [IW-1:0] rs1_idx,
  input  logic [IW-1:0] rs2_idx,
  input  logic [IW-1:0] rd_idx,
  output logic          rs1_pend_nxt,
  output logic          rs2_pend_nxt,
  output logic          rd_pend_nxt
);

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;

  // Set is applied after clear so a same-index collision leaves the bit pending.
  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_idx] = 1'b0;
    if (set_en) sb_d[set_idx] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  // Reads return next cycle's contents, letting the owner classify one edge ahead.
  assign rs1_pend_nxt = sb_d[rs1_idx];
  assign rs2_pend_nxt = sb_d[rs2_idx];
  assign rd_pend_nxt  = sb_d[rd_idx];

endmodule

// File: rtl/id_issue_ctrl.sv
// rtl/id_issue_ctrl.sv - IF/ID slot owner: hazard-gated issue to EX with scoreboard tracking and flush
module id_issue_ctrl
  import rv32_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NREG        = 32,
  parameter int STALL_CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  id_issue_ctrl_if.slave bus
);

  id_state_t              state_q, state_d;
  logic [XLEN-1:0]        instr_q, pc_q;
  logic [STALL_CNT_W-1:0] stall_q;

  logic       slot_valid, id_valid, if_ready, issue_fire, accept;
  logic [6:0] op_n;
  logic [4:0] rd_n, rs1_n, rs2_n;
  logic       rs1_pend_n, rs2_pend_n, rd_pend_n, hazard_n;

  assign slot_valid = (state_q != EMPTY);
  assign id_valid   = (state_q == FULL) && !bus.flush;
  assign issue_fire = id_valid && bus.id_ready;
  assign if_ready   = !slot_valid || issue_fire || bus.flush;
  assign accept     = bus.if_valid && if_ready;

  // Fields of whatever instruction will occupy the slot next cycle.
  assign op_n  = accept ? bus.if_instr[6:0]   : instr_q[6:0];
  assign rd_n  = accept ? bus.if_instr[11:7]  : instr_q[11:7];
  assign rs1_n = accept ? bus.if_instr[19:15] : instr_q[19:15];
  assign rs2_n = accept ? bus.if_instr[24:20] : instr_q[24:20];

  reg_scoreboard #(.NREG(NREG)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .set_en       (issue_fire && op_writes_rd(instr_q[6:0])),
    .set_idx      (instr_q[11:7]),
    .clr_en       (bus.wb_valid),
    .clr_idx      (bus.wb_rd),
    .rs1_idx      (rs1_n),
    .rs2_idx      (rs2_n),
    .rd_idx       (rd_n),
    .rs1_pend_nxt (rs1_pend_n),
    .rs2_pend_nxt (rs2_pend_n),
    .rd_pend_nxt  (rd_pend_n)
  );

  assign hazard_n = (op_uses_rs1(op_n)  && rs1_pend_n) ||
                    (op_uses_rs2(op_n)  && rs2_pend_n) ||
                    (op_writes_rd(op_n) && rd_pend_n);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = hazard_n ? STALL : FULL;
      end
      FULL: begin
        if (accept)                        state_d = hazard_n ? STALL : FULL;
        else if (issue_fire || bus.flush)  state_d = EMPTY;
        else                               state_d = hazard_n ? STALL : FULL;
      end
      STALL: begin
        if (accept)          state_d = hazard_n ? STALL : FULL;
        else if (bus.flush)  state_d = EMPTY;
        else if (!hazard_n)  state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      stall_q <= '0;
    end else begin
      if (accept) begin
        instr_q <= bus.if_instr;
        pc_q    <= bus.if_pc;
      end
      if ((state_q == STALL) && (stall_q != '1)) stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign bus.if_ready   = if_ready;
  assign bus.id_valid   = id_valid;
  assign bus.id_instr   = instr_q;
  assign bus.id_pc      = pc_q;
  assign bus.id_illegal = slot_valid && op_illegal(instr_q[6:0]);
  assign bus.stall_cnt  = stall_q;

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Decode-stage controller of the RV32 core.
- Owns the IF/ID instruction register and presents the held instruction to the combinational decoder.
- Tracks pending register writes in a 32-entry scoreboard and stalls issue on RAW/WAW hazards.
- Sequences the valid/ready handshakes to fetch (upstream) and execute (downstream), and drops the held instruction on a pipeline flush.

Parameters:
- XLEN, 32, width of instruction and PC.
- NREG, 32, architectural register count (scoreboard depth); x0 never pending.
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  controller accepts the fetch instruction this cycle.
- if_instr  in  XLEN  fetched instruction.
- if_pc  in  XLEN  PC of the fetched instruction.
- flush  in  1  redirect from EX; kill the IF/ID slot.
- id_valid  out  1  held instruction is hazard-free and offered to EX.
- id_ready  in  1  EX accepts the instruction.
- id_instr  out  XLEN  held instruction (feeds decoder).
- id_pc  out  XLEN  held PC.
- id_illegal  out  1  held opcode is not one of the 9 supported RV32I opcodes.
- wb_valid  in  1  writeback retires a register write.
- wb_rd  in  5  register written back.
- stall_cnt  out  STALL_CNT_W  cycles spent in STALL, saturating.

Behaviour:
- Reset: state=EMPTY, slot invalid, scoreboard=0, stall_cnt=0; id_instr=0, id_pc=0, id_valid=0, id_illegal=0, if_ready=1.
- Field extraction: opcode=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
- uses_rs1: R, LOAD, OP-IMM, STORE, BRANCH, JALR.
- uses_rs2: R, STORE, BRANCH.
- writes_rd: R, LOAD, OP-IMM, LUI, AUIPC, JAL, JALR.
- Illegal opcodes: uses/writes nothing; id_illegal=1; still issued so EX can trap.
- hazard = slot valid AND ((uses_rs1 AND sb[rs1]) OR (uses_rs2 AND sb[rs2]) OR (writes_rd AND sb[rd])). Index 0 is always treated as not pending.
- Hazard checks use the registered scoreboard only. A same-cycle wb clear is not bypassed; it takes effect next cycle.
- issue_fire = id_valid AND id_ready.
- id_valid = slot valid AND NOT hazard AND NOT flush.
- if_ready = NOT slot valid OR issue_fire OR flush.
- accept = if_valid AND if_ready. Zero-bubble: fire and accept in the same cycle reloads the slot.
- FSM states:
  - EMPTY: slot invalid.
  - FULL: valid, no hazard.
  - STALL: valid, hazard.
- FSM transitions:
  - EMPTY -> FULL/STALL on accept, classified next cycle from the new instruction.
  - FULL -> EMPTY on fire without accept; stays FULL/STALL on fire+accept; stays FULL while EX backpressures.
  - STALL -> FULL when the blocking bit clears; id_valid rises one cycle after the wb that clears it.
- flush: slot invalid next cycle unless accept happens in the same cycle, in which case the new instruction loads (flush kills only the old one). No issue occurs while flush is high. Scoreboard is unchanged.
- Scoreboard update, per cycle:
  - Set sb[rd] on issue_fire when writes_rd and rd!=0.
  - Clear sb[wb_rd] on wb_valid.
  - Same index set and clear in one cycle: set wins.
- stall_cnt: +1 each cycle in STALL, saturating at all-ones.
- Reset mid-operation: all state, including in-flight scoreboard bits, returns to reset values next edge.

Decomposition:
- Package rv32_pkg holds:
  - opcode localparams: OP_R=0110011, OP_LOAD=0000011, OP_IMM=0010011, OP_STORE=0100011, OP_BRANCH=1100011, OP_LUI=0110111, OP_AUIPC=0010111, OP_JAL=1101111, OP_JALR=1100111;
  - typedef enum id_state_t {EMPTY, FULL, STALL}.
- One natural sub-module: reg_scoreboard (NREG bits; set/clear ports; two read ports plus an rd read port; x0 hard-zero).

Test Plan:
- No-hazard stream: the two instructions below presented back-to-back with id_ready=1 issue on consecutive cycles; stall_cnt=0.
  - addi x1,x0,5 = 0x00500093
  - addi x2,x0,7 = 0x00700113
- RAW stall: issue lw x5,0(x1); then present add x6,x5,x5 -> id_valid=0 and state STALL until wb_valid=1,wb_rd=5; id_valid=1 the following cycle; stall_cnt = stall cycles.
- Backpressure: id_ready=0 for 3 cycles with FULL slot -> if_ready=0, id_instr stable, stall_cnt unchanged; fire on 4th cycle.
- Flush: STALL slot holding add x6,x5,x5, flush=1 with if_valid=0 -> EMPTY next cycle; sb[5] still set; later wb_rd=5 clears it.
- Set/clear collision and x0: issue addi x3 while wb_valid=1,wb_rd=3 -> sb[3]=1. Issue addi x0,x0,0 -> scoreboard unchanged, no stall.
- Illegal + reset: opcode 0x7F -> id_illegal=1, issues without hazard check; assert rst mid-STALL -> all outputs/scoreboard at reset values next cycle.
